hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the decode stage. It keeps a per-register in-flight scoreboard between ID issue and WB commit, and detects read-after-write hazards on the instruction in ID. On a hazard it stalls IF/ID and inserts a bubble into ID→EX. It also flushes wrong-path instructions on a taken branch and drains, then freezes, the pipeline on HALT.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; register 0 is constant zero.
- MAX_INFLIGHT, 3, maximum outstanding writers per register; counter width is clog2(MAX_INFLIGHT+1).
- HALT_OP, 6'b010001, opcode that triggers drain and halt.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  instruction present in ID.
- id_opcode  in  6  opcode of ID instruction.
- id_rs / id_rt  in  5 each  source register indices.
- id_rs_used / id_rt_used  in  1 each  source is actually read.
- id_rd  in  5  destination index.
- id_rd_wr  in  1  instruction writes id_rd.
- ex_branch_taken  in  1  branch/JR resolved taken in EX this cycle.
- wb_we  in  1  register-file write this cycle.
- wb_addr  in  5  register-file write index.
- stall_if  out  1  hold PC and IF/ID register.
- bubble_ex  out  1  load zeros (NOP, all control 0) into ID→EX.
- flush  out  1  invalidate IF/ID contents.
- halted  out  1  pipeline frozen after HALT.
- stall_cycles  out  16  RAW-stall performance count.

## Operation
- Scoreboard: cnt[r] per register, reset 0.
  - issue = id_valid & ~stall_if & ~ex_branch_taken & state==RUN.
  - inc when issue & id_rd_wr & id_rd!=0; dec when wb_we & wb_addr!=0 (dec at cnt 0 is ignored and never underflows).
  - Inc and dec of the same register in the same cycle leave cnt unchanged.
  - cnt[0] is always 0.
- raw = id_valid & ((id_rs_used & id_rs!=0 & cnt[id_rs]!=0) | (id_rt_used & id_rt!=0 & cnt[id_rt]!=0)).
- waw_full = id_valid & id_rd_wr & id_rd!=0 & cnt[id_rd]==MAX_INFLIGHT.
- FSM states and transitions:
  - RUN:
    - raw|waw_full → stall_if=1, bubble_ex=1, next STALL.
    - Issue of HALT_OP → next DRAIN. The HALT itself issues as a NOP.
  - STALL: same outputs while raw|waw_full persists; when both clear, the instruction issues and the FSM returns to RUN in the same cycle (next=RUN).
  - DRAIN: stall_if=1, bubble_ex=1; when all cnt==0 → HALTED.
  - HALTED: stall_if=1, bubble_ex=1, halted=1; leaves only on reset.
- ex_branch_taken overrides all states except HALTED:
  - flush=1, bubble_ex=1, stall_if=0, no issue.
  - From STALL or DRAIN, next state is RUN; a HALT in DRAIN is treated as wrong-path and cancelled.
- WB decrements continue in every state, including DRAIN and HALTED.

## Timing
- stall_if, bubble_ex and flush are combinational from the current state, the scoreboard and the inputs, so they are asserted in the same cycle as the condition.
- The scoreboard and state update on posedge clk. The register file writes at the same edge as the WB decrement, so a dependent instruction issues in the cycle after the WB cycle (one stall cycle after the WB cycle).
- halted rises one cycle after the cycle in which the last cnt reaches 0 (registered state).
- Reset, including mid-stall or mid-drain:
  - State is RUN, all cnt are 0 and stall_cycles is 0.
  - stall_if, bubble_ex, flush and halted are held at 0 while reset=1.
- An id_valid=0 cycle never stalls, never issues and never flushes unless ex_branch_taken=1.

## Configuration
- HAZARD_CTRL_PERF_EN defined: stall_cycles increments by 1 on each clk where stall_if=1 in RUN/STALL due to raw|waw_full. It saturates at 16'hFFFF and resets to 0.
- HAZARD_CTRL_PERF_EN undefined: stall_cycles is tied to 0 and no counter is built.

## Test plan
- Back-to-back dependency: issue add r3 (rd=3), next ID reads rs=3, WB r3 three cycles later. Required: stall_if=bubble_ex=1 for 3 cycles, then issue; stall_cycles=3 with PERF_EN.
- Register 0: ID writes rd=0, then the next instruction reads rs=0. Required: cnt[0] stays 0 and there is no stall.
- Simultaneous issue and WB to r5 with cnt[5]=1: cnt[5] stays 1. Issue 3 writers to r7 (MAX_INFLIGHT=3) with no WB, then a fourth writer → waw_full stall until a WB to r7.
- Taken branch during STALL on r4: flush=1, bubble_ex=1, stall_if=0 that cycle, no issue; next state is RUN and cnt[4] is unchanged.
- HALT with r2 and r9 in flight: DRAIN holds stall_if=1 until both WBs complete, then halted=1 on the next cycle and stays high until reset.
- Assert reset mid-DRAIN with cnt[6]=2. Required: all outputs 0 during reset; after release, RUN with an empty scoreboard.

Source files
------------

// File: rtl/hazard_ctrl.sv
//==============================================================================
// Module   : hazard_ctrl
// Purpose  : Decode-stage sequencing: per-register in-flight scoreboard, RAW/WAW
//            stall with bubble insertion, taken-branch flush, HALT drain/freeze.
// Option   : HAZARD_CTRL_PERF_EN enables the saturating RAW-stall cycle counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int         NUM_REGS     = 32,
    parameter int         MAX_INFLIGHT = 3,
    parameter logic [5:0] HALT_OP      = 6'b010001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_wr,
    input  logic        ex_branch_taken,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    output logic        stall_if,
    output logic        bubble_ex,
    output logic        flush,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    localparam int              c_CW   = $clog2(MAX_INFLIGHT + 1);
    localparam logic [c_CW-1:0] c_ZERO = '0;
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
    localparam logic [c_CW-1:0] c_MAX  = c_CW'(MAX_INFLIGHT);

    localparam logic [1:0] c_ST_RUN    = 2'd0;
    localparam logic [1:0] c_ST_STALL  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;
    localparam logic [1:0] c_ST_HALTED = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_CW-1:0] r_cnt [NUM_REGS];

    logic w_rs_busy;
    logic w_rt_busy;
    logic w_raw;
    logic w_waw_full;
    logic w_hazard;
    logic w_is_halt;
    logic w_can_issue_state;
    logic w_issue;
    logic w_all_idle;

    assign w_rs_busy  = id_rs_used && (id_rs != 5'd0) && (r_cnt[id_rs] != c_ZERO);
    assign w_rt_busy  = id_rt_used && (id_rt != 5'd0) && (r_cnt[id_rt] != c_ZERO);
    assign w_raw      = id_valid && (w_rs_busy || w_rt_busy);
    assign w_waw_full = id_valid && id_rd_wr && (id_rd != 5'd0) && (r_cnt[id_rd] == c_MAX);
    assign w_hazard   = w_raw || w_waw_full;
    assign w_is_halt  = (id_opcode == HALT_OP);

    // STALL re-issues the held instruction in the cycle its hazard clears.
    assign w_can_issue_state = (r_state == c_ST_RUN) || (r_state == c_ST_STALL);
    assign w_issue = id_valid && !ex_branch_taken && w_can_issue_state && !w_hazard;

    always_comb begin
        w_all_idle = 1'b1;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (r_cnt[r] != c_ZERO) begin
                w_all_idle = 1'b0;
            end
        end
    end

    // Scoreboard: HALT issues as a NOP and never claims a destination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= c_ZERO;
            end
        end else begin
            r_cnt[0] <= c_ZERO;
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_issue && id_rd_wr && !w_is_halt && (id_rd == 5'(r))) begin
                    if (!(wb_we && (wb_addr == 5'(r)) && (r_cnt[r] != c_ZERO))) begin
                        r_cnt[r] <= r_cnt[r] + c_ONE;
                    end
                end else if (wb_we && (wb_addr == 5'(r)) && (r_cnt[r] != c_ZERO)) begin
                    r_cnt[r] <= r_cnt[r] - c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_RUN, c_ST_STALL: begin
                if (ex_branch_taken) begin
                    w_next = c_ST_RUN;
                end else if (w_hazard) begin
                    w_next = c_ST_STALL;
                end else if (w_issue && w_is_halt) begin
                    w_next = c_ST_DRAIN;
                end else begin
                    w_next = c_ST_RUN;
                end
            end
            c_ST_DRAIN: begin
                if (ex_branch_taken) begin
                    w_next = c_ST_RUN;
                end else if (w_all_idle) begin
                    w_next = c_ST_HALTED;
                end
            end
            c_ST_HALTED: w_next = c_ST_HALTED;
            default:     w_next = c_ST_RUN;
        endcase
    end

    always_comb begin
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush     = 1'b0;
        halted    = 1'b0;
        if (!reset) begin
            if (r_state == c_ST_HALTED) begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
                halted    = 1'b1;
            end else if (ex_branch_taken) begin
                flush     = 1'b1;
                bubble_ex = 1'b1;
            end else if (r_state == c_ST_DRAIN) begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end else if (w_hazard) begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end else if (w_issue && w_is_halt) begin
                bubble_ex = 1'b1;
            end
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    logic [15:0] r_stall_cycles;
    logic        w_perf_hit;

    assign w_perf_hit = w_can_issue_state && !ex_branch_taken && w_hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
        end else if (w_perf_hit && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'd0;
`endif

endmodule

`default_nettype wire
